pipelined_csel_adder: RTL and testbench

- Parametrised, pipelined carry-select adder/subtractor; the successor to the team's fixed 8/16-bit combinational carry-select adders.
- The operand is split into BLOCK-bit slices, and each pipeline stage resolves one slice.
- For each slice, two candidate sums (carry-in 0 and carry-in 1) are computed. The registered carry from the previous stage selects between them.
- Valid/ready handshake on both sides. Sits between operand-issue logic and the result writeback path of the datapath.

---
 rtl/pipelined_csel_adder.sv | 116 +++++++++++
 tb/tb_pipelined_csel_adder.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/pipelined_csel_adder.sv
// Pipelined carry-select adder/subtractor. Each stage resolves one BLOCK-bit slice.
// The unresolved upper operand slices travel down the pipe alongside the partial result.
module pipelined_csel_adder #(
  parameter int WIDTH = 16,
  parameter int BLOCK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int STAGES = WIDTH / BLOCK;

  if (BLOCK < 1 || WIDTH % BLOCK != 0) begin : g_bad_params
    $error("pipelined_csel_adder: WIDTH must be a multiple of BLOCK");
  end

  logic             en;
  logic [WIDTH-1:0] b_eff;

  assign en       = !out_valid || out_ready;
  assign in_ready = en;
  assign b_eff    = b ^ {WIDTH{sub}};

  for (genvar k = 0; k < STAGES; k++) begin : stg
    // REM: operand bits still unresolved on entry to this stage
    localparam int REM = WIDTH - k * BLOCK;

    logic [REM-1:0]           src_a;
    logic [REM-1:0]           src_b;
    logic                     c_in;
    logic                     v_in;
    logic [BLOCK:0]           s0;
    logic [BLOCK:0]           s1;
    logic [BLOCK:0]           sel;
    logic [(k+1)*BLOCK-1:0]   res_d;
    logic [(k+1)*BLOCK-1:0]   res_q;
    logic                     vld_q;
    logic                     cry_q;

    if (k == 0) begin : g_src
      assign src_a = a;
      assign src_b = b_eff;
      assign c_in  = cin;
      assign v_in  = in_valid;
      assign res_d = sel[BLOCK-1:0];
    end else begin : g_src
      assign src_a = stg[k-1].g_fwd.a_q;
      assign src_b = stg[k-1].g_fwd.b_q;
      assign c_in  = stg[k-1].cry_q;
      assign v_in  = stg[k-1].vld_q;
      assign res_d = {sel[BLOCK-1:0], stg[k-1].res_q};
    end

    assign s0  = {1'b0, src_a[BLOCK-1:0]} + {1'b0, src_b[BLOCK-1:0]};
    assign s1  = {1'b0, src_a[BLOCK-1:0]} + {1'b0, src_b[BLOCK-1:0]} + (BLOCK+1)'(1);
    assign sel = c_in ? s1 : s0;

    always_ff @(posedge clk) begin
      if (rst) begin
        vld_q <= 1'b0;
        cry_q <= 1'b0;
        res_q <= '0;
      end else if (en) begin
        vld_q <= v_in;
        cry_q <= sel[BLOCK];
        res_q <= res_d;
      end
    end

    if (k < STAGES - 1) begin : g_fwd
      logic [REM-BLOCK-1:0] a_q;
      logic [REM-BLOCK-1:0] b_q;

      always_ff @(posedge clk) begin
        if (rst) begin
          a_q <= '0;
          b_q <= '0;
        end else if (en) begin
          a_q <= src_a[REM-1:BLOCK];
          b_q <= src_b[REM-1:BLOCK];
        end
      end
    end else begin : g_last
      logic c_msb;
      logic ovf_q;

      // carry into the top bit recovered from the sum bit: s = a ^ b ^ c
      assign c_msb = src_a[BLOCK-1] ^ src_b[BLOCK-1] ^ sel[BLOCK-1];

      always_ff @(posedge clk) begin
        if (rst) begin
          ovf_q <= 1'b0;
        end else if (en) begin
          ovf_q <= c_msb ^ sel[BLOCK];
        end
      end
    end
  end

  assign out_valid = stg[STAGES-1].vld_q;
  assign sum       = stg[STAGES-1].res_q;
  assign cout      = stg[STAGES-1].cry_q;
  assign ovf       = stg[STAGES-1].g_last.ovf_q;

endmodule

// File: tb/tb_pipelined_csel_adder.sv
// Scoreboard bench for pipelined_csel_adder (WIDTH=16, BLOCK=4, latency 4).
// Inputs change on the falling edge; outputs are sampled 1 ns later.
module tb_pipelined_csel_adder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        cin = 1'b0;
  logic        sub = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] sum;
  logic        cout;
  logic        ovf;

  int errors = 0;
  int checks = 0;
  logic [17:0] exp_q[$];

  pipelined_csel_adder #(.WIDTH(16), .BLOCK(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // returns {ovf, cout, sum}; overflow from operand/result signs
  function automatic logic [17:0] model(input logic [15:0] ta, input logic [15:0] tb,
                                        input logic tc, input logic ts);
    logic [15:0] be;
    logic [16:0] f;
    logic        o;
    be = tb ^ {16{ts}};
    f  = {1'b0, ta} + {1'b0, be} + 17'(tc);
    o  = (ta[15] == be[15]) && (f[15] != ta[15]);
    return {o, f};
  endfunction

  // one clock: drive, settle, score output handshake, record accept, advance to next falling edge
  task automatic step(input bit iv, input logic [15:0] ta, input logic [15:0] tb,
                      input bit tc, input bit ts, input bit ordy,
                      output bit acc, output bit rdy);
    logic [17:0] e;
    in_valid = iv; a = ta; b = tb; cin = tc; sub = ts; out_ready = ordy;
    #1;
    rdy = in_ready;
    if (out_valid && out_ready) begin
      check("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("result", {14'd0, ovf, cout, sum}, {14'd0, e});
      end
    end
    acc = iv && rdy;
    if (acc) exp_q.push_back(model(ta, tb, tc, ts));
    @(negedge clk);
  endtask

  task automatic idle(input bit ordy);
    bit acc, rdy;
    step(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, ordy, acc, rdy);
  endtask

  task automatic lat_run(input logic [15:0] ta, input logic [15:0] tb, input bit tc, input bit ts,
                         input logic [15:0] es, input bit ec, input bit eo);
    bit acc, rdy;
    step(1'b1, ta, tb, tc, ts, 1'b1, acc, rdy);
    check("lat_accept", 32'(acc), 32'd1);
    for (int i = 0; i < 3; i++) begin
      check("lat_early", 32'(out_valid), 32'd0);
      idle(1'b1);
    end
    check("lat_valid", 32'(out_valid), 32'd1);
    check("lat_sum", 32'(sum), 32'(es));
    check("lat_cout", 32'(cout), 32'(ec));
    check("lat_ovf", 32'(ovf), 32'(eo));
    idle(1'b1);
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      idle(1'b1);
      n++;
    end
    check(tag, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    bit acc, rdy;
    int idx, sent, cyc;
    logic [15:0] sa, sb;

    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);

    lat_run(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    lat_run(16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    lat_run(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    lat_run(16'h1234, 16'h0FFF, 1'b1, 1'b0, 16'h2234, 1'b0, 1'b0);

    // eight back-to-back ops with a three-cycle downstream stall
    idx = 0;
    for (int c = 0; c < 40 && (idx < 8 || exp_q.size() != 0); c++) begin
      bit ordy;
      ordy = !(c >= 5 && c < 8);
      if (c >= 5 && c < 8) begin
        check("stall_valid", 32'(out_valid), 32'd1);
        if (exp_q.size() != 0)
          check("stall_hold", {14'd0, ovf, cout, sum}, {14'd0, exp_q[0]});
      end
      sa = 16'(idx * 16'h2345 + 16'h0007);
      sb = 16'(idx * 16'h1F1F);
      step(idx < 8, sa, sb, idx[0], idx[1], ordy, acc, rdy);
      if (!ordy) check("stall_in_ready", 32'(rdy), 32'd0);
      if (acc) idx++;
    end
    check("stall_count", 32'(idx), 32'd8);
    drain("stall_drain");

    // reset with three ops in flight
    for (int i = 0; i < 3; i++)
      step(1'b1, 16'(16'h0101 * (i + 1)), 16'h3333, 1'b0, 1'b0, 1'b1, acc, rdy);
    rst = 1'b1;
    idle(1'b1);
    rst = 1'b0;
    exp_q.delete();
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < 5; i++) begin
      check("midrst_no_stale", 32'(out_valid), 32'd0);
      idle(1'b1);
    end
    lat_run(16'h00F0, 16'h0F0F, 1'b0, 1'b0, 16'h0FFF, 1'b0, 1'b0);

    // random traffic with 50% downstream readiness
    sent = 0;
    cyc = 0;
    while (sent < 10000 && cyc < 60000) begin
      step($urandom_range(0, 3) != 0, 16'($urandom), 16'($urandom),
           1'($urandom), 1'($urandom), 1'($urandom), acc, rdy);
      if (acc) sent++;
      cyc++;
    end
    check("rand_sent", 32'(sent), 32'd10000);
    drain("rand_drain");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
